// File: rtl/serial_port_arbiter.sv
// Two-client arbiter for the serial port byte interface: message-locked TX ownership
// with idle timeout, per-byte RX arbitration, and one-cycle settle gaps after every strobe.
module serial_port_arbiter #(
    parameter int          IDLE_TIMEOUT = 16,
    parameter logic [7:0]  EOM_BYTE     = 8'h0A
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       c0_wr_req,
    input  logic       c1_wr_req,
    input  logic [7:0] c0_wr_data,
    input  logic [7:0] c1_wr_data,
    output logic       c0_wr_ack,
    output logic       c1_wr_ack,
    output logic       c0_tx_grant,
    output logic       c1_tx_grant,
    input  logic       c0_rd_req,
    input  logic       c1_rd_req,
    output logic [7:0] c0_rd_data,
    output logic [7:0] c1_rd_data,
    output logic       c0_rd_valid,
    output logic       c1_rd_valid,
    input  logic       s_data_valid_in,
    input  logic [7:0] s_data_in,
    input  logic       s_data_ready_in,
    output logic       s_rden_out,
    output logic [7:0] s_data_out,
    output logic       s_wren_out
);

    localparam int              CW      = $clog2(IDLE_TIMEOUT);
    localparam logic [CW-1:0]   CNT_MAX = CW'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {TX_IDLE, TX_OWN, TX_GAP} tx_state_e;
    typedef enum logic       {RX_IDLE, RX_GAP}         rx_state_e;

    logic [1:0]      wr_req;
    logic [1:0][7:0] wr_data;
    logic [1:0]      rd_req;

    assign wr_req  = {c1_wr_req, c0_wr_req};
    assign wr_data = {c1_wr_data, c0_wr_data};
    assign rd_req  = {c1_rd_req, c0_rd_req};

    tx_state_e       tx_state_q, tx_state_d;
    logic            owner_q, owner_d;
    logic            tx_last_q, tx_last_d;
    logic [1:0]      tx_grant_q, tx_grant_d;
    logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
    logic [1:0]      wr_ack_q, wr_ack_d;
    logic            s_wren_q, s_wren_d;
    logic [7:0]      s_data_q, s_data_d;

    rx_state_e       rx_state_q, rx_state_d;
    logic            rx_last_q, rx_last_d;
    logic [1:0]      rd_valid_q, rd_valid_d;
    logic [1:0][7:0] rd_data_q, rd_data_d;
    logic            s_rden_q, s_rden_d;

    logic            tx_pick, rx_pick;

    // On contention the client that did not go last wins; otherwise whoever asks.
    assign tx_pick = (&wr_req) ? ~tx_last_q : wr_req[1];
    assign rx_pick = (&rd_req) ? ~rx_last_q : rd_req[1];

    always_comb begin
        tx_state_d = tx_state_q;
        owner_d    = owner_q;
        tx_last_d  = tx_last_q;
        tx_grant_d = tx_grant_q;
        idle_cnt_d = idle_cnt_q;
        wr_ack_d   = '0;
        s_wren_d   = 1'b0;
        s_data_d   = s_data_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (|wr_req) begin
                    owner_d    = tx_pick;
                    tx_grant_d = 2'b01 << tx_pick;
                    idle_cnt_d = '0;
                    tx_state_d = TX_OWN;
                end
            end
            TX_OWN: begin
                if (wr_req[owner_q]) begin
                    if (s_data_ready_in) begin
                        s_data_d          = wr_data[owner_q];
                        s_wren_d          = 1'b1;
                        wr_ack_d[owner_q] = 1'b1;
                        idle_cnt_d        = '0;
                        tx_state_d        = TX_GAP;
                    end
                end else if (idle_cnt_q == CNT_MAX) begin
                    tx_grant_d = '0;
                    tx_last_d  = owner_q;
                    tx_state_d = TX_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            TX_GAP: begin
                // s_data_q still holds the byte just accepted.
                if (s_data_q == EOM_BYTE) begin
                    tx_grant_d = '0;
                    tx_last_d  = owner_q;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_state_d = TX_OWN;
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_last_d  = rx_last_q;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        s_rden_d   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (s_data_valid_in && (|rd_req)) begin
                    s_rden_d           = 1'b1;
                    rd_data_d[rx_pick] = s_data_in;
                    rd_valid_d[rx_pick] = 1'b1;
                    rx_last_d          = rx_pick;
                    rx_state_d         = RX_GAP;
                end
            end
            RX_GAP:  rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tx_state_q <= TX_IDLE;
            owner_q    <= 1'b0;
            tx_last_q  <= 1'b1;
            tx_grant_q <= '0;
            idle_cnt_q <= '0;
            wr_ack_q   <= '0;
            s_wren_q   <= 1'b0;
            s_data_q   <= '0;
            rx_state_q <= RX_IDLE;
            rx_last_q  <= 1'b1;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            s_rden_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            owner_q    <= owner_d;
            tx_last_q  <= tx_last_d;
            tx_grant_q <= tx_grant_d;
            idle_cnt_q <= idle_cnt_d;
            wr_ack_q   <= wr_ack_d;
            s_wren_q   <= s_wren_d;
            s_data_q   <= s_data_d;
            rx_state_q <= rx_state_d;
            rx_last_q  <= rx_last_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            s_rden_q   <= s_rden_d;
        end
    end

    assign c0_wr_ack   = wr_ack_q[0];
    assign c1_wr_ack   = wr_ack_q[1];
    assign c0_tx_grant = tx_grant_q[0];
    assign c1_tx_grant = tx_grant_q[1];
    assign s_wren_out  = s_wren_q;
    assign s_data_out  = s_data_q;
    assign c0_rd_valid = rd_valid_q[0];
    assign c1_rd_valid = rd_valid_q[1];
    assign c0_rd_data  = rd_data_q[0];
    assign c1_rd_data  = rd_data_q[1];
    assign s_rden_out  = s_rden_q;

endmodule

// File: tb/tb_serial_port_arbiter.sv
// Directed bench for serial_port_arbiter: TX lock/EOM, timeout, fairness,
// backpressure, reset mid-message and RX per-byte arbitration.
module tb_serial_port_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       c0_wr_req, c1_wr_req;
    logic [7:0] c0_wr_data, c1_wr_data;
    logic       c0_wr_ack, c1_wr_ack;
    logic       c0_tx_grant, c1_tx_grant;
    logic       c0_rd_req, c1_rd_req;
    logic [7:0] c0_rd_data, c1_rd_data;
    logic       c0_rd_valid, c1_rd_valid;
    logic       s_data_valid_in;
    logic [7:0] s_data_in;
    logic       s_data_ready_in;
    logic       s_rden_out;
    logic [7:0] s_data_out;
    logic       s_wren_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    serial_port_arbiter #(.IDLE_TIMEOUT(16), .EOM_BYTE(8'h0A)) dut (
        .clock(clock), .reset(reset),
        .c0_wr_req(c0_wr_req), .c1_wr_req(c1_wr_req),
        .c0_wr_data(c0_wr_data), .c1_wr_data(c1_wr_data),
        .c0_wr_ack(c0_wr_ack), .c1_wr_ack(c1_wr_ack),
        .c0_tx_grant(c0_tx_grant), .c1_tx_grant(c1_tx_grant),
        .c0_rd_req(c0_rd_req), .c1_rd_req(c1_rd_req),
        .c0_rd_data(c0_rd_data), .c1_rd_data(c1_rd_data),
        .c0_rd_valid(c0_rd_valid), .c1_rd_valid(c1_rd_valid),
        .s_data_valid_in(s_data_valid_in), .s_data_in(s_data_in),
        .s_data_ready_in(s_data_ready_in), .s_rden_out(s_rden_out),
        .s_data_out(s_data_out), .s_wren_out(s_wren_out)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Packs {c1_grant,c0_grant,c1_ack,c0_ack,wren} for compact checks.
    function automatic logic [4:0] txv();
        return {c1_tx_grant, c0_tx_grant, c1_wr_ack, c0_wr_ack, s_wren_out};
    endfunction

    initial begin
        reset = 1'b1;
        c0_wr_req = 0; c1_wr_req = 0; c0_wr_data = 0; c1_wr_data = 0;
        c0_rd_req = 0; c1_rd_req = 0;
        s_data_valid_in = 0; s_data_in = 0; s_data_ready_in = 0;
        tick(); tick();
        chk("rst_tx", {27'd0, txv()}, 32'h0);
        chk("rst_rx", {c1_rd_valid, c0_rd_valid, s_rden_out}, 3'b000);
        chk("rst_data", {s_data_out, c0_rd_data, c1_rd_data}, 24'h0);
        reset = 1'b0;

        // Both request from reset: c0 wins, keeps the lock through 0x48 then 0x0A.
        c0_wr_req = 1; c0_wr_data = 8'h48;
        c1_wr_req = 1; c1_wr_data = 8'h55;
        s_data_ready_in = 1;
        tick(); chk("lock_grant", txv(), 5'b01000);
        tick(); chk("lock_b0", txv(), 5'b01011);
        chk("lock_b0_data", s_data_out, 8'h48);
        c0_wr_data = 8'h0A;
        tick(); chk("lock_gap", txv(), 5'b01000);
        tick(); chk("lock_eom", txv(), 5'b01011);
        chk("lock_eom_data", s_data_out, 8'h0A);
        c0_wr_req = 0;
        tick(); chk("eom_release", txv(), 5'b00000);
        tick(); chk("c1_grant", txv(), 5'b10000);

        // Backpressure: c1 owns, ready low for 10 cycles, no strobe and no timeout.
        s_data_ready_in = 0;
        for (int i = 0; i < 10; i++) begin
            tick(); chk("bp_hold", txv(), 5'b10000);
        end
        s_data_ready_in = 1;
        tick(); chk("bp_write", txv(), 5'b10101);
        chk("bp_data", s_data_out, 8'h55);

        // Reset during TX_GAP: everything clears, contention order restarts at c0.
        reset = 1;
        tick(); chk("rst_gap", {27'd0, txv()}, 32'h0);
        chk("rst_gap_data", s_data_out, 8'h00);
        reset = 0;
        c0_wr_req = 1; c0_wr_data = 8'h33;
        tick(); chk("post_rst_grant", txv(), 5'b01000);

        // Timeout: c0 idles while c1 keeps requesting.
        c0_wr_req = 0;
        for (int i = 1; i <= 15; i++) begin
            tick(); chk("to_hold", txv(), 5'b01000);
        end
        tick(); chk("to_release", txv(), 5'b00000);
        tick(); chk("to_c1_grant", txv(), 5'b10000);
        c1_wr_req = 0;

        // RX fairness: both ask, c0 gets 0x10, c1 gets 0x11 two cycles later.
        reset = 1;
        tick();
        reset = 0;
        c0_rd_req = 1; c1_rd_req = 1;
        s_data_valid_in = 1; s_data_in = 8'h10;
        tick(); chk("rx0_strobe", {c1_rd_valid, c0_rd_valid, s_rden_out}, 3'b011);
        chk("rx0_data", c0_rd_data, 8'h10);
        s_data_in = 8'h11;
        tick(); chk("rx_gap", {c1_rd_valid, c0_rd_valid, s_rden_out}, 3'b000);
        chk("rx0_hold", c0_rd_data, 8'h10);
        tick(); chk("rx1_strobe", {c1_rd_valid, c0_rd_valid, s_rden_out}, 3'b101);
        chk("rx1_data", c1_rd_data, 8'h11);

        // RX and TX together: c1 alone reads 0x22 while c0 writes 0x7E.
        c0_rd_req = 0; s_data_in = 8'h22;
        c0_wr_req = 1; c0_wr_data = 8'h7E;
        tick(); chk("mix_gap", {c1_rd_valid, s_rden_out, c0_tx_grant}, 3'b001);
        tick(); chk("mix_both", {c1_rd_valid, s_rden_out, txv()}, 7'b1101011);
        chk("mix_data", {s_data_out, c1_rd_data, c0_rd_data}, 24'h7E2210);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serial_port_arbiter.md
# serial_port_arbiter

Shares the single memory-mapped serial port's byte-stream side between two clients (client 0, client 1): a CPU core and a debug/boot loader. Transmit access is message-locked: the granted client keeps the port until it sends an end-of-message byte or goes idle. Receive access is granted one byte at a time. Sits between the clients and the serial buffer's s_* byte interface. It sequences every s_wren_out/s_rden_out pulse and enforces one-cycle gaps so that the port's status flags can settle.

## Interface
- IDLE_TIMEOUT, 16: cycles the TX owner may leave c*_wr_req low before it loses ownership (≥2).
- EOM_BYTE, 8'h0A: byte value that ends a TX message and releases ownership.
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- c0_wr_req, c1_wr_req  in  1  client wants to send byte; held until ack.
- c0_wr_data, c1_wr_data  in  8  byte to send; stable while req high.
- c0_wr_ack, c1_wr_ack  out  1  one-cycle pulse: byte accepted.
- c0_tx_grant, c1_tx_grant  out  1  client currently owns TX.
- c0_rd_req, c1_rd_req  in  1  client wants a received byte.
- c0_rd_data, c1_rd_data  out  8  received byte, valid with rd_valid, held until next delivery.
- c0_rd_valid, c1_rd_valid  out  1  one-cycle pulse: rd_data is new.
- s_data_valid_in  in  1  port has an RX byte.
- s_data_in  in  8  current RX byte.
- s_data_ready_in  in  1  port can accept a TX byte.
- s_rden_out  out  1  one-cycle pop of the RX byte.
- s_data_out  out  8  TX byte, valid with s_wren_out, held afterwards.
- s_wren_out  out  1  one-cycle TX write strobe.

## Operation
- Reset: all outputs 0. TX state is TX_IDLE with no owner. RX state is RX_IDLE. tx_last and rx_last are both 1, so client 0 wins the first contention. The timeout counter is 0.
- TX FSM: TX_IDLE → TX_OWN → TX_GAP → (TX_OWN | TX_IDLE).
  - TX_IDLE: if any c*_wr_req is high, the next edge sets the owner, raises c*_tx_grant, clears the counter and moves to TX_OWN. If both clients request, the owner is the client that is not tx_last.
  - TX_OWN: if the owner's wr_req and s_data_ready_in are both high, the next edge drives s_data_out = owner's wr_data, sets s_wren_out = 1 and owner's wr_ack = 1, clears the counter and moves to TX_GAP.
  - TX_OWN, owner's wr_req high but ready low: wait; the counter holds.
  - TX_OWN, owner's wr_req low: the counter increments. When counter = IDLE_TIMEOUT-1, the next edge releases ownership (grant = 0, tx_last = owner) and moves to TX_IDLE.
  - TX_GAP: lasts exactly one cycle and ignores all requests. If the accepted byte == EOM_BYTE, go to TX_IDLE and release ownership (tx_last = owner); otherwise return to TX_OWN.
  - The non-owner's wr_req is ignored until ownership is released.
- RX FSM: RX_IDLE → RX_GAP → RX_IDLE.
  - RX_IDLE: if s_data_valid_in is high and any c*_rd_req is high, pick a client (the one that is not rx_last on contention). The next edge sets s_rden_out = 1, that client's rd_data = s_data_in and its rd_valid = 1, sets rx_last to that client, and moves to RX_GAP.
  - RX_GAP: lasts one cycle, with no pops.
  - RX arbitration is per byte and independent of TX ownership.
- The TX and RX FSMs run concurrently. A TX write and an RX pop may occur in the same cycle.
- Counter width is $clog2(IDLE_TIMEOUT); it never wraps past IDLE_TIMEOUT-1.

## Timing
- TX latency: request sampled at edge T, with ownership already held and ready high → s_wren_out/ack high during cycle T+1.
- From TX_IDLE: grant at T+1, strobe at T+2.
- Sustained TX throughput: one byte per 2 cycles. The RX rate is the same.
- All strobes are registered single-cycle pulses; no combinational path from inputs to outputs.
- Reset asserted mid-message: the next edge forces the reset values; any pending byte is dropped without an ack.
- s_data_ready_in falling in the same cycle as a request: no write; retry when ready returns.

## Test plan
- Single TX: c0 sends 0x41 with ready = 1 → grant next cycle, s_wren_out with s_data_out = 0x41 one cycle later, c0_wr_ack in the same cycle, c0 keeps the grant.
- Message lock and EOM: c0 sends 0x48 then 0x0A while c1_wr_req is held high → both c0 bytes are written before any c1 byte, c0 is released after 0x0A, c1 is granted 2 cycles after the 0x0A strobe.
- Timeout: c0 is granted then idles → the grant drops after exactly 16 idle cycles; with c1 requesting, c1 is granted the next cycle.
- Contention fairness: both clients request TX from reset → c0 is granted first; after its release with both requesting again, c1 is granted. The same check on RX with s_data_valid_in = 1 and bytes 0x10, 0x11 → c0 gets 0x10, c1 gets 0x11, with s_rden_out pulses 2 cycles apart.
- Backpressure/reset: ready = 0 while c1 requests with 0x55 → no strobe for 10 cycles and no timeout; raising ready → 0x55 is written. Asserting reset during TX_GAP → all outputs 0 on the next cycle and the owner is cleared.
